// File: rtl/stream_split_pkg.sv
// Shared helpers for the stream split/join FIFOs: depth derived from address size.
package stream_split_pkg;

  function automatic int fifo_depth(input int addr_sz);
    return 1 << addr_sz;
  endfunction

endpackage

// File: rtl/stream_split_fifo.sv
// First-word-fall-through FIFO with registered storage and an async active-high
// reset that clears pointers and count only; data outputs read 0 while empty.
module stream_split_fifo
  import stream_split_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR_SZ = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr,
  input  logic [WIDTH-1:0]   i_data,
  output logic               o_full,
  input  logic               i_rd,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_empty,
  output logic [ADDR_SZ:0]   o_count
);

  localparam int DEPTH = fifo_depth(ADDR_SZ);
  localparam logic [ADDR_SZ:0] FULL_CNT = (ADDR_SZ+1)'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_SZ-1:0] wr_ptr;
  logic [ADDR_SZ-1:0] rd_ptr;
  logic [ADDR_SZ:0]   count;
  logic               wr;
  logic               rd;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

  // Guard both sides locally so a caller cannot overrun or underrun.
  assign wr = i_wr && !o_full;
  assign rd = i_rd && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/stream_split.sv
// Forks one {left, right} valid/ready stream into two independently buffered
// streams. Define STREAMSPLIT_LEVEL_EN to expose per-side FIFO fill levels.
module stream_split
  import stream_split_pkg::*;
#(
  parameter int LEFT_WIDTH   = 8,
  parameter int RIGHT_WIDTH  = 8,
  parameter int FIFO_ADDR_SZ = 1,
  parameter int IN_WIDTH     = LEFT_WIDTH + RIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [IN_WIDTH-1:0]     i_data,
  output logic                    o_left_valid,
  input  logic                    o_left_ready,
  output logic [LEFT_WIDTH-1:0]   o_left_data,
  output logic                    o_right_valid,
  input  logic                    o_right_ready,
  output logic [RIGHT_WIDTH-1:0]  o_right_data
`ifdef STREAMSPLIT_LEVEL_EN
  ,
  output logic [FIFO_ADDR_SZ:0]   o_left_level,
  output logic [FIFO_ADDR_SZ:0]   o_right_level
`endif
);

  logic                  left_full,  right_full;
  logic                  left_empty, right_empty;
  logic [FIFO_ADDR_SZ:0] left_count, right_count;
  logic                  accept;

  // Ready depends only on registered counts, never on downstream ready.
  assign i_ready = !reset && !left_full && !right_full;
  assign accept  = i_valid && i_ready;

  assign o_left_valid  = !left_empty;
  assign o_right_valid = !right_empty;

  stream_split_fifo #(.WIDTH(LEFT_WIDTH), .ADDR_SZ(FIFO_ADDR_SZ)) u_left (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (accept),
    .i_data  (i_data[IN_WIDTH-1:RIGHT_WIDTH]),
    .o_full  (left_full),
    .i_rd    (o_left_ready),
    .o_data  (o_left_data),
    .o_empty (left_empty),
    .o_count (left_count)
  );

  stream_split_fifo #(.WIDTH(RIGHT_WIDTH), .ADDR_SZ(FIFO_ADDR_SZ)) u_right (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (accept),
    .i_data  (i_data[RIGHT_WIDTH-1:0]),
    .o_full  (right_full),
    .i_rd    (o_right_ready),
    .o_data  (o_right_data),
    .o_empty (right_empty),
    .o_count (right_count)
  );

`ifdef STREAMSPLIT_LEVEL_EN
  assign o_left_level  = left_count;
  assign o_right_level = right_count;
`else
  logic unused_count;
  assign unused_count = ^{left_count, right_count};
`endif

endmodule

// File: tb/tb_stream_split.sv
// Directed bench for stream_split (8/8 widths, depth 2); level checks are
// compiled in only when STREAMSPLIT_LEVEL_EN is defined.
module tb_stream_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_data;
  logic        o_left_valid;
  logic        o_left_ready;
  logic [7:0]  o_left_data;
  logic        o_right_valid;
  logic        o_right_ready;
  logic [7:0]  o_right_data;
`ifdef STREAMSPLIT_LEVEL_EN
  logic [1:0]  o_left_level;
  logic [1:0]  o_right_level;
`endif

  int checks = 0;
  int errors = 0;
  int accepts;

  always #5 clk = ~clk;

  stream_split #(.LEFT_WIDTH(8), .RIGHT_WIDTH(8), .FIFO_ADDR_SZ(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .i_ready       (i_ready),
    .i_data        (i_data),
    .o_left_valid  (o_left_valid),
    .o_left_ready  (o_left_ready),
    .o_left_data   (o_left_data),
    .o_right_valid (o_right_valid),
    .o_right_ready (o_right_ready),
    .o_right_data  (o_right_data)
`ifdef STREAMSPLIT_LEVEL_EN
    ,
    .o_left_level  (o_left_level),
    .o_right_level (o_right_level)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_side(input string tag, input logic lv, input logic [7:0] ld,
                          input logic rv, input logic [7:0] rd);
    chk({tag, "_lv"}, 32'(o_left_valid),  32'(lv));
    chk({tag, "_ld"}, 32'(o_left_data),   32'(ld));
    chk({tag, "_rv"}, 32'(o_right_valid), 32'(rv));
    chk({tag, "_rd"}, 32'(o_right_data),  32'(rd));
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0;
    o_left_ready = 1'b1; o_right_ready = 1'b1;
    step(); step();

    // Reset state
    chk_side("rst", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("rst_irdy", 32'(i_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_irdy", 32'(i_ready), 32'd1);
`ifdef STREAMSPLIT_LEVEL_EN
    chk("rel_llvl", 32'(o_left_level), 32'd0);
    chk("rel_rlvl", 32'(o_right_level), 32'd0);
`endif
    step();

    // Single beat, 1-cycle latency, drains next cycle
    i_valid = 1'b1; i_data = 16'hA55A;
    chk_side("one_pre", 1'b0, 8'h00, 1'b0, 8'h00);
    step();
    i_valid = 1'b0;
    chk_side("one", 1'b1, 8'hA5, 1'b1, 8'h5A);
    step();
    chk_side("one_drain", 1'b0, 8'h00, 1'b0, 8'h00);

    // Right side stalls; left drains independently until right fills
    o_right_ready = 1'b0;
    i_valid = 1'b1; i_data = 16'h0102;
    step();
    i_data = 16'h0304;
    chk_side("stl1", 1'b1, 8'h01, 1'b1, 8'h02);
    chk("stl1_irdy", 32'(i_ready), 32'd1);
    step();
    i_data = 16'h0506;
    chk_side("stl2", 1'b1, 8'h03, 1'b1, 8'h02);
    chk("stl2_irdy", 32'(i_ready), 32'd0);
    step();
    chk_side("stl3", 1'b0, 8'h00, 1'b1, 8'h02);
    chk("stl3_irdy", 32'(i_ready), 32'd0);
    o_right_ready = 1'b1;
    #1;
    chk("stl3_irdy_rr", 32'(i_ready), 32'd0);
    step();
    chk_side("stl4", 1'b0, 8'h00, 1'b1, 8'h04);
    chk("stl4_irdy", 32'(i_ready), 32'd1);
    step();
    i_valid = 1'b0;
    chk_side("stl5", 1'b1, 8'h05, 1'b1, 8'h06);
    step();
    chk_side("stl6", 1'b0, 8'h00, 1'b0, 8'h00);

    // Back-to-back throughput, one beat per cycle
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_data  = {k[7:0], k[7:0]};
      if (i_ready) accepts++;
      step();
      chk_side($sformatf("bb%0d", k), 1'b1, k[7:0], 1'b1, k[7:0]);
    end
    i_valid = 1'b0;
    chk("bb_accepts", 32'(accepts), 32'd10);
    step();
    chk_side("bb_drain", 1'b0, 8'h00, 1'b0, 8'h00);

    // Async reset mid-cycle with two beats queued
    o_left_ready = 1'b0; o_right_ready = 1'b0;
    i_valid = 1'b1; i_data = 16'h1122;
    step();
    i_data = 16'h3344;
    step();
    i_valid = 1'b0;
    chk_side("ar_pre", 1'b1, 8'h11, 1'b1, 8'h22);
    chk("ar_pre_irdy", 32'(i_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_side("ar_mid", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ar_mid_irdy", 32'(i_ready), 32'd0);
    step();
    reset = 1'b0;
    o_left_ready = 1'b1; o_right_ready = 1'b1;
    #1;
    chk_side("ar_rel", 1'b0, 8'h00, 1'b0, 8'h00);
    chk("ar_rel_irdy", 32'(i_ready), 32'd1);
    step(); step();
    chk_side("ar_after", 1'b0, 8'h00, 1'b0, 8'h00);

`ifdef STREAMSPLIT_LEVEL_EN
    // Left stalled, right drains: levels 2 and 0
    o_left_ready = 1'b0; o_right_ready = 1'b1;
    i_valid = 1'b1; i_data = 16'hAA55;
    step();
    i_data = 16'hBB66;
    step();
    i_valid = 1'b0;
    step();
    chk("lvl_left", 32'(o_left_level), 32'd2);
    chk("lvl_right", 32'(o_right_level), 32'd0);
    chk("lvl_ldata", 32'(o_left_data), 32'hAA);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
